// File: rtl/mmio_pkg.sv
// Shared register map, TCON bit positions and offset decode for the MMIO timer block.
package mmio_pkg;

   localparam int unsigned WINDOW_BYTES = 32;

   localparam logic [4:0] OFF_TH      = 5'h00;
   localparam logic [4:0] OFF_TL      = 5'h04;
   localparam logic [4:0] OFF_TCON    = 5'h08;
   localparam logic [4:0] OFF_LED     = 5'h0C;
   localparam logic [4:0] OFF_SYSTICK = 5'h10;

   localparam int EN_BIT = 0;
   localparam int IE_BIT = 1;
   localparam int ST_BIT = 2;

   typedef enum logic [2:0] {
      SEL_TH      = 3'd0,
      SEL_TL      = 3'd1,
      SEL_TCON    = 3'd2,
      SEL_LED     = 3'd3,
      SEL_SYSTICK = 3'd4,
      SEL_NONE    = 3'd5
   } reg_sel_e;

   // Byte-lane bits are dropped so any address within a word selects that word.
   function automatic reg_sel_e decode_offset(input logic [4:0] off);
      logic [4:0] word_off;
      word_off = {off[4:2], 2'b00};
      case (word_off)
         OFF_TH:      decode_offset = SEL_TH;
         OFF_TL:      decode_offset = SEL_TL;
         OFF_TCON:    decode_offset = SEL_TCON;
         OFF_LED:     decode_offset = SEL_LED;
         OFF_SYSTICK: decode_offset = SEL_SYSTICK;
         default:     decode_offset = SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mmio_timer_tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high for one cycle at each wrap.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] r_cnt;
   logic        w_wrap;

   assign w_wrap = (r_cnt == LAST);
   assign tick   = en & w_wrap;

   // Prescale counter; dropping en discards any partial count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= 16'h0000;
      end else if (!en || w_wrap) begin
         r_cnt <= 16'h0000;
      end else begin
         r_cnt <= r_cnt + 16'h0001;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped reload timer with level interrupt, LED register and free-running systick.
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] Read_data,
   output logic        hit,
   output logic        irq,
   output logic [7:0]  leds,
   output logic [31:0] systick
);

   logic [31:0] r_th;
   logic [31:0] r_tl;
   logic [2:0]  r_tcon;
   logic [7:0]  r_led;
   logic [31:0] r_systick;

   reg_sel_e    w_sel;
   logic        w_tick;
   logic        w_ovf;
   logic        w_wr_th;
   logic        w_wr_tl;
   logic        w_wr_tcon;
   logic        w_wr_led;

   assign hit       = (Address[31:5] == BASE_ADDR[31:5]);
   assign w_sel     = decode_offset(Address[4:0]);
   assign w_wr_th   = MemWrite & hit & (w_sel == SEL_TH);
   assign w_wr_tl   = MemWrite & hit & (w_sel == SEL_TL);
   assign w_wr_tcon = MemWrite & hit & (w_sel == SEL_TCON);
   assign w_wr_led  = MemWrite & hit & (w_sel == SEL_LED);
   assign w_ovf     = (r_tl == 32'hFFFF_FFFF);

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (r_tcon[EN_BIT]),
      .tick  (w_tick)
   );

   // Reload value; overflow reloads from the value held before this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_th <= 32'h0000_0000;
      end else if (w_wr_th) begin
         r_th <= Write_data;
      end else begin
         r_th <= r_th;
      end
   end

   // Timer counter; a bus store overrides a same-edge tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tl <= 32'h0000_0000;
      end else if (w_wr_tl) begin
         r_tl <= Write_data;
      end else if (w_tick) begin
         r_tl <= w_ovf ? r_th : (r_tl + 32'h0000_0001);
      end else begin
         r_tl <= r_tl;
      end
   end

   // Control/status; a TCON store replaces all three bits, losing a same-edge ST set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tcon <= 3'b000;
      end else if (w_wr_tcon) begin
         r_tcon <= Write_data[2:0];
      end else if (w_tick && w_ovf && r_tcon[IE_BIT]) begin
         r_tcon[ST_BIT] <= 1'b1;
      end else begin
         r_tcon <= r_tcon;
      end
   end

   // LED output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_led <= 8'h00;
      end else if (w_wr_led) begin
         r_led <= Write_data[7:0];
      end else begin
         r_led <= r_led;
      end
   end

   // Free-running cycle counter with no write path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_systick <= 32'h0000_0000;
      end else begin
         r_systick <= r_systick + 32'h0000_0001;
      end
   end

   // Load data mux; shows pre-write contents during a simultaneous store.
   always_comb begin
      Read_data = 32'h0000_0000;
      if (MemRead && hit) begin
         case (w_sel)
            SEL_TH:      Read_data = r_th;
            SEL_TL:      Read_data = r_tl;
            SEL_TCON:    Read_data = {29'h0000_0000, r_tcon};
            SEL_LED:     Read_data = {24'h00_0000, r_led};
            SEL_SYSTICK: Read_data = r_systick;
            default:     Read_data = 32'h0000_0000;
         endcase
      end else begin
         Read_data = 32'h0000_0000;
      end
   end

   assign irq     = r_tcon[IE_BIT] & r_tcon[ST_BIT];
   assign leds    = r_led;
   assign systick = r_systick;

endmodule
